// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : Instruction-fetch stage. Owns the program counter, fetches
//                from instruction memory over a req/ack handshake, and loads
//                the IF/ID pipeline register. It also has a one-entry skid
//                buffer that catches an instruction acked while ID is stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] pc_o,
    output logic        if_id_valid_o,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] if_id_pc4_o
);

    // Force the reset PC onto a word boundary.
    localparam logic [31:0] c_reset_pc = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_if_id_valid;
    logic [31:0] r_if_id_instr;
    logic [31:0] r_if_id_pc4;
    logic        r_skid_valid;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc4;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_pc;
    logic        w_unused_bits;

    // Wraps modulo 2^32, so 32'hFFFF_FFFC steps to 32'h0.
    assign w_pc_plus4    = r_pc + 32'd4;
    // The low two bits of a redirect target are dropped.
    assign w_redirect_pc = {redirect_pc_i[31:2], 2'b00};
    assign w_unused_bits = ^redirect_pc_i[1:0];

    // The request comes only from state, and the address comes only from the PC register.
    assign imem_req_o    = (r_state == ST_REQ);
    assign imem_addr_o   = r_pc;
    assign pc_o          = r_pc;
    assign if_id_valid_o = r_if_id_valid;
    assign if_id_instr_o = r_if_id_instr;
    assign if_id_pc4_o   = r_if_id_pc4;

    // Fetch FSM: this block updates the PC, the IF/ID register and the skid buffer.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state       <= ST_IDLE;
            r_pc          <= c_reset_pc;
            r_if_id_valid <= 1'b0;
            r_if_id_instr <= 32'h0;
            r_if_id_pc4   <= 32'h0;
            r_skid_valid  <= 1'b0;
            r_skid_instr  <= 32'h0;
            r_skid_pc4    <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // In IDLE, flush is ignored. A redirect still moves the PC.
                    if (redirect_i) begin
                        r_pc <= w_redirect_pc;
                    end
                    if (start_i) begin
                        r_state <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    if (redirect_i) begin
                        // Drop any ack in this cycle. IF/ID only holds its value on a stall with no flush.
                        r_pc         <= w_redirect_pc;
                        r_skid_valid <= 1'b0;
                        if (flush_i || !stall_i) begin
                            r_if_id_valid <= 1'b0;
                            r_if_id_instr <= 32'h0;
                        end
                    end else if (flush_i) begin
                        r_if_id_valid <= 1'b0;
                        r_if_id_instr <= 32'h0;
                    end else if (imem_ack_i) begin
                        r_pc <= w_pc_plus4;
                        if (stall_i) begin
                            // ID cannot accept the word yet, so park it in the skid buffer.
                            r_skid_valid <= 1'b1;
                            r_skid_instr <= imem_data_i;
                            r_skid_pc4   <= w_pc_plus4;
                            r_state      <= ST_HOLD;
                        end else begin
                            r_if_id_valid <= 1'b1;
                            r_if_id_instr <= imem_data_i;
                            r_if_id_pc4   <= w_pc_plus4;
                        end
                    end else if (!stall_i) begin
                        // Waiting on memory: insert a bubble and keep pc4.
                        r_if_id_valid <= 1'b0;
                        r_if_id_instr <= 32'h0;
                    end
                end

                ST_HOLD: begin
                    if (redirect_i) begin
                        r_pc         <= w_redirect_pc;
                        r_skid_valid <= 1'b0;
                        r_state      <= ST_REQ;
                        if (flush_i || !stall_i) begin
                            r_if_id_valid <= 1'b0;
                            r_if_id_instr <= 32'h0;
                        end
                    end else if (flush_i) begin
                        // Stay in HOLD and keep the skid contents.
                        r_if_id_valid <= 1'b0;
                        r_if_id_instr <= 32'h0;
                    end else if (!stall_i) begin
                        r_if_id_valid <= r_skid_valid;
                        r_if_id_instr <= r_skid_instr;
                        r_if_id_pc4   <= r_skid_pc4;
                        r_skid_valid  <= 1'b0;
                        r_state       <= ST_REQ;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_stage
//  Description : Self-checking bench for if_stage. It uses a scoreboard of
//                expected IF/ID contents and a word-addressed memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    localparam logic [31:0] c_key = 32'hA5A5_0000;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic        stall_i;
    logic        flush_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic [31:0] pc_o;
    logic        if_id_valid_o;
    logic [31:0] if_id_instr_o;
    logic [31:0] if_id_pc4_o;

    logic        ack_en;
    int          errors;
    int          checks;
    logic [63:0] sb[$];
    logic [63:0] exp_e;
    logic [32:0] last_pc4;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_data_i   (imem_data_i),
        .pc_o          (pc_o),
        .if_id_valid_o (if_id_valid_o),
        .if_id_instr_o (if_id_instr_o),
        .if_id_pc4_o   (if_id_pc4_o)
    );

    // Memory model: the word at an address is addr ^ key. It acks only a live request.
    assign imem_data_i = imem_addr_o ^ c_key;
    assign imem_ack_i  = ack_en & imem_req_o;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b0; start_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        redirect_i = 1'b0; redirect_pc_i = 32'h0; ack_en = 1'b0;
        step(); step();
        rst_i = 1'b1;
        step(); step(); step();
        checks++;
        if ({imem_req_o, pc_o, if_id_valid_o} !== {1'b0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_idle: req=%0b pc=%h valid=%0b, want 0/00000000/0",
                     imem_req_o, pc_o, if_id_valid_o);
        end
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        checks++;
        if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL start_req: req=%0b addr=%h, want 1/00000000", imem_req_o, imem_addr_o);
        end
    endtask

    task automatic test_zero_wait();
        ack_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (imem_addr_o !== 32'(4 * k)) begin
                errors++;
                $display("FAIL zw_addr%0d: addr=%h want %h", k, imem_addr_o, 32'(4 * k));
            end
            sb.push_back({32'(4 * k) ^ c_key, 32'(4 * k + 4)});
            step();
            if (sb.size() == 0) exp_e = '1; else exp_e = sb.pop_front();
            checks++;
            if ({if_id_valid_o, if_id_instr_o, if_id_pc4_o} !== {1'b1, exp_e}) begin
                errors++;
                $display("FAIL zw_ifid%0d: v=%0b instr=%h pc4=%h want 1 %h %h",
                         k, if_id_valid_o, if_id_instr_o, if_id_pc4_o, exp_e[63:32], exp_e[31:0]);
            end
        end
        ack_en = 1'b0;
    endtask

    task automatic test_wait_states();
        logic [31:0] exp_addr;
        exp_addr = 32'd16;
        last_pc4 = {1'b0, 32'd16};
        for (int f = 0; f < 2; f++) begin
            for (int w = 0; w < 2; w++) begin
                step();
                checks++;
                if ({if_id_valid_o, if_id_instr_o, if_id_pc4_o, imem_addr_o, imem_req_o} !==
                    {1'b0, 32'h0, last_pc4[31:0], exp_addr, 1'b1}) begin
                    errors++;
                    $display("FAIL wait_bubble%0d_%0d: v=%0b instr=%h pc4=%h addr=%h req=%0b want 0 0 %h %h 1",
                             f, w, if_id_valid_o, if_id_instr_o, if_id_pc4_o, imem_addr_o, imem_req_o,
                             last_pc4[31:0], exp_addr);
                end
            end
            ack_en = 1'b1;
            sb.push_back({exp_addr ^ c_key, exp_addr + 32'd4});
            step();
            ack_en = 1'b0;
            if (sb.size() == 0) exp_e = '1; else exp_e = sb.pop_front();
            checks++;
            if ({if_id_valid_o, if_id_instr_o, if_id_pc4_o} !== {1'b1, exp_e}) begin
                errors++;
                $display("FAIL wait_ifid%0d: v=%0b instr=%h pc4=%h want 1 %h %h",
                         f, if_id_valid_o, if_id_instr_o, if_id_pc4_o, exp_e[63:32], exp_e[31:0]);
            end
            exp_addr = exp_addr + 32'd4;
            last_pc4 = {1'b0, exp_addr};
        end
    endtask

    task automatic test_stall_skid();
        // PC is 24 and IF/ID holds the instruction from address 20.
        ack_en  = 1'b1;
        stall_i = 1'b1;
        sb.push_back({32'd24 ^ c_key, 32'd28});
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({imem_req_o, if_id_valid_o, if_id_instr_o, pc_o} !==
                {1'b0, 1'b1, 32'd20 ^ c_key, 32'd28}) begin
                errors++;
                $display("FAIL stall_hold%0d: req=%0b v=%0b instr=%h pc=%h want 0 1 %h 0000001c",
                         c, imem_req_o, if_id_valid_o, if_id_instr_o, pc_o, 32'd20 ^ c_key);
            end
        end
        stall_i = 1'b0;
        ack_en  = 1'b0;
        step();
        if (sb.size() == 0) exp_e = '1; else exp_e = sb.pop_front();
        checks++;
        if ({if_id_valid_o, if_id_instr_o, if_id_pc4_o} !== {1'b1, exp_e}) begin
            errors++;
            $display("FAIL stall_release: v=%0b instr=%h pc4=%h want 1 %h %h",
                     if_id_valid_o, if_id_instr_o, if_id_pc4_o, exp_e[63:32], exp_e[31:0]);
        end
        checks++;
        if ({imem_req_o, imem_addr_o} !== {1'b1, 32'd28}) begin
            errors++;
            $display("FAIL stall_next_req: req=%0b addr=%h want 1 0000001c", imem_req_o, imem_addr_o);
        end
    endtask

    task automatic test_flush_redirect();
        ack_en = 1'b1; flush_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
        step();
        ack_en = 1'b0; flush_i = 1'b0; redirect_i = 1'b0;
        checks++;
        if ({if_id_valid_o, if_id_instr_o, if_id_pc4_o, imem_addr_o, imem_req_o} !==
            {1'b0, 32'h0, 32'd28, 32'h0000_0100, 1'b1}) begin
            errors++;
            $display("FAIL flush_redir: v=%0b instr=%h pc4=%h addr=%h req=%0b want 0 0 0000001c 00000100 1",
                     if_id_valid_o, if_id_instr_o, if_id_pc4_o, imem_addr_o, imem_req_o);
        end
        ack_en = 1'b1;
        sb.push_back({32'h100 ^ c_key, 32'h104});
        step();
        ack_en = 1'b0;
        if (sb.size() == 0) exp_e = '1; else exp_e = sb.pop_front();
        checks++;
        if ({if_id_valid_o, if_id_instr_o, if_id_pc4_o} !== {1'b1, exp_e}) begin
            errors++;
            $display("FAIL redir_fetch: v=%0b instr=%h pc4=%h want 1 %h %h",
                     if_id_valid_o, if_id_instr_o, if_id_pc4_o, exp_e[63:32], exp_e[31:0]);
        end
        // A redirect with no flush while stalled keeps IF/ID and drops the ack.
        ack_en = 1'b1; stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
        step();
        ack_en = 1'b0; stall_i = 1'b0; redirect_i = 1'b0;
        checks++;
        if ({if_id_valid_o, if_id_instr_o, imem_addr_o, imem_req_o} !==
            {1'b1, 32'h100 ^ c_key, 32'h0000_0200, 1'b1}) begin
            errors++;
            $display("FAIL redir_stall: v=%0b instr=%h addr=%h req=%0b want 1 %h 00000200 1",
                     if_id_valid_o, if_id_instr_o, imem_addr_o, imem_req_o, 32'h100 ^ c_key);
        end
    endtask

    task automatic test_wrap_async_reset();
        flush_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        step();
        flush_i = 1'b0; redirect_i = 1'b0;
        checks++;
        if (imem_addr_o !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_addr: addr=%h want fffffffc", imem_addr_o);
        end
        for (int k = 0; k < 2; k++) begin
            ack_en = 1'b1;
            sb.push_back({imem_addr_o ^ c_key, (k == 0) ? 32'h0 : 32'h4});
            step();
            ack_en = 1'b0;
            if (sb.size() == 0) exp_e = '1; else exp_e = sb.pop_front();
            checks++;
            if ({if_id_valid_o, if_id_instr_o, if_id_pc4_o} !== {1'b1, exp_e}) begin
                errors++;
                $display("FAIL wrap_ifid%0d: v=%0b instr=%h pc4=%h want 1 %h %h",
                         k, if_id_valid_o, if_id_instr_o, if_id_pc4_o, exp_e[63:32], exp_e[31:0]);
            end
            checks++;
            if (imem_addr_o !== ((k == 0) ? 32'h0 : 32'h4)) begin
                errors++;
                $display("FAIL wrap_next%0d: addr=%h want %h", k, imem_addr_o, (k == 0) ? 32'h0 : 32'h4);
            end
        end
        // Wait with ID stalled so that IF/ID keeps a valid instruction.
        stall_i = 1'b1;
        step();
        #2;
        rst_i = 1'b0;
        #1;
        checks++;
        if ({imem_req_o, pc_o, if_id_valid_o, if_id_instr_o, if_id_pc4_o} !==
            {1'b0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL async_reset: req=%0b pc=%h v=%0b instr=%h pc4=%h want all zero",
                     imem_req_o, pc_o, if_id_valid_o, if_id_instr_o, if_id_pc4_o);
        end
        stall_i = 1'b0;
        step();
        rst_i = 1'b1;
        step();
        checks++;
        if (imem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: req=%0b want 0", imem_req_o);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall_skid();
        test_flush_redirect();
        test_wrap_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage feeding the IF/ID boundary of the pipelined CPU. It owns the program counter and issues requests to instruction memory over a req/ack handshake. It holds the fetched instruction and PC+4 in the IF/ID register consumed by Control, Registers and HazardDetection. Stall comes from HazardDetection; flush and redirect come from branch/jump resolution.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  leaves IDLE when sampled high
- stall_i  in  1  hold IF/ID contents (HazardDetection)
- flush_i  in  1  squash IF/ID to bubble
- redirect_i  in  1  load PC from redirect_pc_i
- redirect_pc_i  in  32  branch/jump target; bits [1:0] ignored
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  fetch address (= pc_o)
- imem_ack_i  in  1  imem_data_i valid for the presented address, this cycle
- imem_data_i  in  32  instruction word
- pc_o  out  32  current fetch PC
- if_id_valid_o  out  1  IF/ID holds a real instruction
- if_id_instr_o  out  32  IF/ID instruction; 32'h0 (NOP) when invalid
- if_id_pc4_o  out  32  IF/ID PC+4

## Operation
- Reset (rst_i low, any time, asynchronous): pc=RESET_PC, state=IDLE, if_id_valid_o=0, if_id_instr_o=0, if_id_pc4_o=0, skid buffer empty. imem_req_o=0, because it is decoded from state. Any in-flight request is abandoned.
- The PC is always word-aligned. Bits [1:0] are 0 in every state.
- Increment is pc+4 modulo 2^32: 32'hFFFF_FFFC -> 32'h0.
- IDLE state:
  - imem_req_o=0.
  - start_i=1 at an edge -> REQ.
  - start_i is ignored in all other states.
- REQ state: imem_req_o=1, imem_addr_o=pc. The address is stable until ack or redirect. Priority is flush/redirect > stall > normal. Per edge:
  - ack=1, stall_i=0: IF/ID <= {1, imem_data_i, pc+4}; pc <= pc+4; stay REQ.
  - ack=1, stall_i=1: skid <= {imem_data_i, pc+4}; pc <= pc+4; IF/ID unchanged; -> HOLD.
  - ack=0, stall_i=0: IF/ID <= bubble (valid=0, instr=0, pc4 unchanged); pc unchanged.
  - ack=0, stall_i=1: IF/ID and pc unchanged.
- HOLD state:
  - imem_req_o=0.
  - stall_i=0 -> IF/ID <= {1, skid}; -> REQ.
  - stall_i=1 -> remain in HOLD.
- flush_i=1, any non-IDLE state:
  - IF/ID <= bubble, regardless of stall_i.
  - Any ack in that cycle is discarded and the PC does not advance.
  - State REQ, or HOLD with skid retained, unless redirect also applies.
- redirect_i=1, any non-IDLE state:
  - pc <= {redirect_pc_i[31:2], 2'b00}; skid discarded; -> REQ.
  - An ack in the same cycle is discarded.
  - IF/ID follows the stall rule unless flush_i is also high. Branch logic normally asserts both.
- flush_i/redirect_i in IDLE: ignored, except that redirect still loads pc.
- Abandoning a request is achieved by changing imem_addr_o or dropping imem_req_o. Memory must not ack a stale address.

## Timing
- First request is driven in the cycle after the start_i edge.
- With a zero-wait memory (ack in the same cycle as req), throughput is 1 instruction/cycle and fetch-to-IF/ID latency is 1 edge.
- With N wait cycles, the instruction appears in IF/ID after the edge on which ack=1; N bubbles are inserted if ID is not stalled.
- Stall resolution from HOLD takes 1 cycle. imem_req_o rises in the cycle after IF/ID loads from the skid buffer.
- Redirect: the new address is presented on the cycle after the redirect edge. One bubble enters IF/ID with flush.
- All outputs are registered, or decoded from state/pc only. There is no combinational path from imem_ack_i or stall_i to imem_req_o or imem_addr_o.

## Test plan
- Reset/start: hold rst_i low, then release with start_i=0 for 3 cycles -> imem_req_o=0, pc_o=0, if_id_valid_o=0. Pulse start_i -> next cycle imem_req_o=1, imem_addr_o=0.
- Zero-wait stream: ack tied high with data=addr^32'hA5A5_0000 -> IF/ID shows instr for addr 0,4,8,12 on consecutive cycles, with if_id_pc4_o=4,8,12,16.
- Wait states: ack low 2 cycles per fetch -> two cycles with valid=0/instr=0 between each valid instruction; imem_addr_o stable while waiting.
- Stall with skid: stall_i high for 3 cycles starting on an ack edge of addr 8 -> IF/ID holds the addr-4 instruction and imem_req_o=0 in HOLD. On release, IF/ID = addr-8 instr; the next request is addr 12.
- Flush+redirect to 32'h0000_0103 during an acked fetch -> ack data dropped; IF/ID bubble; next imem_addr_o=32'h0000_0100.
- Wrap and async reset: redirect to 32'hFFFF_FFFC, ack -> if_id_pc4_o=0 and the next address is 0. Assert rst_i mid-wait -> all outputs return to reset values immediately, without waiting for a clock edge.
